// File: rtl/rld_read_dispatcher_pkg.sv
// ============================================================================
// Module   : rld_read_dispatcher_pkg
// Brief    : Shared state encodings for the RLDRAM read dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rld_read_dispatcher_pkg;

    // Same encodings the write arbiter uses, so traces read the same on both sides.
    localparam int         c_STATE_W = 2;
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/rld_read_dispatcher_tag_fifo.sv
// ============================================================================
// Module   : rld_read_dispatcher_tag_fifo
// Brief    : Synchronous FIFO of queue ids for requests awaiting read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rld_read_dispatcher_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full    = (r_count == (c_PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/rld_read_dispatcher.sv
// ============================================================================
// Module   : rld_read_dispatcher
// Brief    : Round-robin RLDRAM read request issue and return-data steering.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rld_read_dispatcher
    import rld_read_dispatcher_pkg::*;
#(
    parameter int TDATA_WIDTH     = 32,
    parameter int NUM_QUEUES      = 4,
    parameter int QUEUE_ID_WIDTH  = 2,
    parameter int BURST_LEN       = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                               memclk,
    input  logic                               reset,
    input  logic [NUM_QUEUES-1:0]              mem_queue_empty,
    input  logic [NUM_QUEUES-1:0]              out_almost_full,
    output logic                               rd_req,
    output logic [QUEUE_ID_WIDTH-1:0]          rd_req_queue_id,
    input  logic                               rd_req_ready,
    input  logic                               rd_data_valid,
    input  logic [8*TDATA_WIDTH+8:0]           rd_data,
    output logic [NUM_QUEUES-1:0]              out_wr_en,
    output logic [8*TDATA_WIDTH+8:0]           out_dout,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               err_unexpected
);

    localparam int c_WORD_W = 8*TDATA_WIDTH + 9;
    localparam int c_BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [c_STATE_W-1:0]      r_state;
    logic                      r_rd_req;
    logic [QUEUE_ID_WIDTH-1:0] r_rd_req_queue_id;
    logic [QUEUE_ID_WIDTH-1:0] r_rr_ptr;
    logic [c_BEAT_W-1:0]       r_beat;
    logic [NUM_QUEUES-1:0]     r_out_wr_en;
    logic [c_WORD_W-1:0]       r_out_dout;
    logic                      r_err;

    logic [NUM_QUEUES-1:0]     w_eligible;
    logic                      w_pick_valid;
    logic [QUEUE_ID_WIDTH-1:0] w_pick_id;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_data_ok;
    logic                      w_last_beat;
    logic [QUEUE_ID_WIDTH-1:0] w_head;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;

    assign w_eligible  = ~mem_queue_empty & ~out_almost_full;
    assign w_push      = (r_state == c_ST_REQ) && rd_req_ready;
    assign w_data_ok   = rd_data_valid && !w_fifo_empty;
    assign w_last_beat = (r_beat == c_BEAT_W'(BURST_LEN-1));
    assign w_pop       = w_data_ok && w_last_beat;

    // First eligible queue strictly after the pointer, wrapping.
    always_comb begin : p_rr_select
        int v_idx;
        w_pick_valid = 1'b0;
        w_pick_id    = '0;
        v_idx        = 0;
        for (int i = 1; i <= NUM_QUEUES; i++) begin
            v_idx = (int'(r_rr_ptr) + i) % NUM_QUEUES;
            if (!w_pick_valid && w_eligible[v_idx[QUEUE_ID_WIDTH-1:0]]) begin
                w_pick_valid = 1'b1;
                w_pick_id    = v_idx[QUEUE_ID_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge memclk) begin
        if (reset) begin
            r_state           <= c_ST_IDLE;
            r_rd_req          <= 1'b0;
            r_rd_req_queue_id <= '0;
            r_rr_ptr          <= QUEUE_ID_WIDTH'(NUM_QUEUES-1);
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_fifo_full && w_pick_valid) begin
                        r_rd_req_queue_id <= w_pick_id;
                        r_rd_req          <= 1'b1;
                        r_state           <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (rd_req_ready) begin
                        r_rr_ptr <= r_rd_req_queue_id;
                        r_rd_req <= 1'b0;
                        r_state  <= c_ST_GAP;
                    end
                end
                // Lets mem_queue_empty catch up with the burst just claimed.
                c_ST_GAP: r_state <= c_ST_IDLE;
                default:  r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge memclk) begin
        if (reset) begin
            r_out_wr_en <= '0;
            r_out_dout  <= '0;
            r_beat      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_out_wr_en <= '0;
            if (w_data_ok) begin
                r_out_wr_en <= NUM_QUEUES'(1) << w_head;
                r_out_dout  <= rd_data;
                r_beat      <= w_last_beat ? '0 : r_beat + c_BEAT_W'(1);
            end
            if (rd_data_valid && w_fifo_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    rld_read_dispatcher_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (QUEUE_ID_WIDTH)
    ) u_tag_fifo (
        .clk     (memclk),
        .rst     (reset),
        .i_push  (w_push),
        .i_din   (r_rd_req_queue_id),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (outstanding)
    );

    assign rd_req          = r_rd_req;
    assign rd_req_queue_id = r_rd_req_queue_id;
    assign out_wr_en       = r_out_wr_en;
    assign out_dout        = r_out_dout;
    assign err_unexpected  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rld_read_dispatcher.sv
// ============================================================================
// Module   : tb_rld_read_dispatcher
// Brief    : Self-checking bench for rld_read_dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rld_read_dispatcher;

    localparam int NQ = 4;
    localparam int QW = 2;
    localparam int BL = 4;
    localparam int MO = 8;
    localparam int WW = 8*32 + 9;

    logic          memclk = 1'b0;
    logic          reset;
    logic [NQ-1:0] mem_queue_empty;
    logic [NQ-1:0] out_almost_full;
    logic          rd_req;
    logic [QW-1:0] rd_req_queue_id;
    logic          rd_req_ready;
    logic          rd_data_valid;
    logic [WW-1:0] rd_data;
    logic [NQ-1:0] out_wr_en;
    logic [WW-1:0] out_dout;
    logic [3:0]    outstanding;
    logic          err_unexpected;

    int n_checks = 0;
    int n_errors = 0;

    always #5 memclk = ~memclk;

    rld_read_dispatcher #(
        .TDATA_WIDTH     (32),
        .NUM_QUEUES      (NQ),
        .QUEUE_ID_WIDTH  (QW),
        .BURST_LEN       (BL),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .memclk          (memclk),
        .reset           (reset),
        .mem_queue_empty (mem_queue_empty),
        .out_almost_full (out_almost_full),
        .rd_req          (rd_req),
        .rd_req_queue_id (rd_req_queue_id),
        .rd_req_ready    (rd_req_ready),
        .rd_data_valid   (rd_data_valid),
        .rd_data         (rd_data),
        .out_wr_en       (out_wr_en),
        .out_dout        (out_dout),
        .outstanding     (outstanding),
        .err_unexpected  (err_unexpected)
    );

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        w = {9'($urandom), $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
        return w;
    endfunction

    // Round-robin reference: first eligible queue strictly after ptr, or -1.
    function automatic int rr_pick(int ptr, logic [NQ-1:0] elig);
        for (int k = 1; k <= NQ; k++) begin
            if (elig[(ptr + k) % NQ]) return (ptr + k) % NQ;
        end
        return -1;
    endfunction

    task automatic idle_inputs();
        mem_queue_empty = '1;
        out_almost_full = '0;
        rd_req_ready    = 1'b0;
        rd_data_valid   = 1'b0;
        rd_data         = '0;
    endtask

    task automatic apply_reset();
        @(negedge memclk);
        reset = 1'b1;
        idle_inputs();
        @(negedge memclk);
        @(negedge memclk);
        reset = 1'b0;
    endtask

    // Presents one eligibility pattern with ready high until a request shows up.
    task automatic issue(input logic [NQ-1:0] mqe, output bit ok, output int id);
        ok = 1'b0;
        id = -1;
        mem_queue_empty = mqe;
        rd_req_ready    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge memclk);
            if (rd_req) begin
                ok = 1'b1;
                id = int'(rd_req_queue_id);
                break;
            end
        end
        mem_queue_empty = '1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge memclk);
        n_checks++;
        if ({rd_req, rd_req_queue_id, out_wr_en, outstanding, err_unexpected} !== '0
            || out_dout !== '0) begin
            n_errors++;
            $display("FAIL reset_state: req=%b id=%0d wr_en=%b outst=%0d err=%b dout_nz=%b, expected all 0",
                     rd_req, rd_req_queue_id, out_wr_en, outstanding, err_unexpected, out_dout != '0);
        end
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        int t_acc[$];
        int id_acc[$];
        int exp_ids[4] = '{0, 2, 0, 2};
        apply_reset();
        mem_queue_empty = 4'b1010;
        rd_req_ready    = 1'b1;
        for (int cyc = 0; cyc < 30 && t_acc.size() < 4; cyc++) begin
            @(negedge memclk);
            if (rd_req) begin
                t_acc.push_back(cyc);
                id_acc.push_back(int'(rd_req_queue_id));
            end
        end
        n_checks++;
        if (t_acc.size() != 4) begin
            n_errors++;
            $display("FAIL rr_count: got %0d requests, expected 4", t_acc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (id_acc[i] != exp_ids[i]) begin
                    n_errors++;
                    $display("FAIL rr_id[%0d]: got %0d expected %0d", i, id_acc[i], exp_ids[i]);
                end
                if (i > 0) begin
                    n_checks++;
                    if (t_acc[i] - t_acc[i-1] != 3) begin
                        n_errors++;
                        $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", i, t_acc[i] - t_acc[i-1]);
                    end
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_hold();
        bit seen;
        int acc;
        apply_reset();
        mem_queue_empty = 4'b1110;
        rd_req_ready    = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge memclk);
            seen = rd_req;
        end
        n_checks++;
        if (!seen || rd_req_queue_id !== 2'd0) begin
            n_errors++;
            $display("FAIL hold_start: req=%b id=%0d, expected req=1 id=0", seen, rd_req_queue_id);
        end
        for (int i = 0; i < 5; i++) begin
            mem_queue_empty[0] = ~mem_queue_empty[0];
            @(negedge memclk);
            n_checks++;
            if (rd_req !== 1'b1 || rd_req_queue_id !== 2'd0) begin
                n_errors++;
                $display("FAIL hold_stable[%0d]: req=%b id=%0d, expected req=1 id=0", i, rd_req, rd_req_queue_id);
            end
        end
        rd_req_ready    = 1'b1;
        mem_queue_empty = '1;
        acc = rd_req ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge memclk);
            if (rd_req && rd_req_ready) acc++;
        end
        n_checks++;
        if (acc != 1 || outstanding !== 4'd1) begin
            n_errors++;
            $display("FAIL hold_accepts: accepts=%0d outst=%0d, expected 1 and 1", acc, outstanding);
        end
        idle_inputs();
    endtask

    task automatic test_return();
        bit ok1, ok2;
        int id1, id2;
        logic [WW-1:0] w [8];
        logic [NQ-1:0] exp_en;
        apply_reset();
        issue(4'b1101, ok1, id1);
        issue(4'b0111, ok2, id2);
        n_checks++;
        if (!ok1 || !ok2 || id1 != 1 || id2 != 3) begin
            n_errors++;
            $display("FAIL ret_ids: got %0d,%0d expected 1,3", id1, id2);
        end
        @(negedge memclk);
        n_checks++;
        if (outstanding !== 4'd2) begin
            n_errors++;
            $display("FAIL ret_outst_start: got %0d expected 2", outstanding);
        end
        for (int i = 0; i < 8; i++) w[i] = rand_word();
        for (int i = 0; i < 8; i++) begin
            rd_data_valid = 1'b1;
            rd_data       = w[i];
            @(negedge memclk);
            exp_en = (i < 4) ? 4'b0010 : 4'b1000;
            n_checks++;
            if (out_wr_en !== exp_en || out_dout !== w[i]) begin
                n_errors++;
                $display("FAIL ret_beat[%0d]: wr_en=%b dout=%h, expected wr_en=%b dout=%h",
                         i, out_wr_en, out_dout, exp_en, w[i]);
            end
            if (i == 3 || i == 7) begin
                n_checks++;
                if (outstanding !== ((i == 3) ? 4'd1 : 4'd0)) begin
                    n_errors++;
                    $display("FAIL ret_outst[%0d]: got %0d expected %0d", i, outstanding, (i == 3) ? 1 : 0);
                end
            end
        end
        rd_data_valid = 1'b0;
        @(negedge memclk);
        n_checks++;
        if (out_wr_en !== '0 || err_unexpected !== 1'b0) begin
            n_errors++;
            $display("FAIL ret_end: wr_en=%b err=%b, expected 0 and 0", out_wr_en, err_unexpected);
        end
        idle_inputs();
    endtask

    task automatic test_full();
        int acc, acc2, first_id;
        apply_reset();
        mem_queue_empty = '0;
        rd_req_ready    = 1'b1;
        acc = 0;
        first_id = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge memclk);
            if (rd_req) begin
                if (acc == 0) first_id = int'(rd_req_queue_id);
                acc++;
            end
        end
        n_checks++;
        if (acc != MO || outstanding !== 4'd8 || rd_req !== 1'b0 || first_id != 0) begin
            n_errors++;
            $display("FAIL full_cap: accepts=%0d outst=%0d req=%b first=%0d, expected 8 8 0 0",
                     acc, outstanding, rd_req, first_id);
        end
        acc2 = 0;
        for (int i = 0; i < 16; i++) begin
            rd_data_valid = (i < BL);
            rd_data       = rand_word();
            @(negedge memclk);
            if (rd_req) acc2++;
            if (i < BL) begin
                n_checks++;
                if (out_wr_en !== 4'b0001) begin
                    n_errors++;
                    $display("FAIL full_ret[%0d]: wr_en=%b expected 0001", i, out_wr_en);
                end
            end
        end
        n_checks++;
        if (acc2 != 1 || outstanding !== 4'd8) begin
            n_errors++;
            $display("FAIL full_refill: requests=%0d outst=%0d, expected 1 and 8", acc2, outstanding);
        end
        idle_inputs();
    endtask

    task automatic test_unexpected();
        apply_reset();
        rd_data_valid = 1'b1;
        rd_data       = rand_word();
        @(negedge memclk);
        rd_data_valid = 1'b0;
        n_checks++;
        if (out_wr_en !== '0 || err_unexpected !== 1'b1) begin
            n_errors++;
            $display("FAIL unexp_set: wr_en=%b err=%b, expected 0 and 1", out_wr_en, err_unexpected);
        end
        repeat (5) @(negedge memclk);
        n_checks++;
        if (err_unexpected !== 1'b1) begin
            n_errors++;
            $display("FAIL unexp_sticky: err=%b expected 1", err_unexpected);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int id;
        apply_reset();
        issue(4'b1011, ok, id);
        @(negedge memclk);
        for (int i = 0; i < 2; i++) begin
            rd_data_valid = 1'b1;
            rd_data       = rand_word();
            @(negedge memclk);
        end
        n_checks++;
        if (!ok || id != 2 || out_wr_en !== 4'b0100) begin
            n_errors++;
            $display("FAIL rmid_pre: ok=%b id=%0d wr_en=%b, expected 1 2 0100", ok, id, out_wr_en);
        end
        reset = 1'b1;
        rd_data = rand_word();
        @(negedge memclk);
        n_checks++;
        if (out_wr_en !== '0 || out_dout !== '0 || outstanding !== '0 || rd_req !== 1'b0
            || err_unexpected !== 1'b0) begin
            n_errors++;
            $display("FAIL rmid_zero: wr_en=%b outst=%0d req=%b err=%b dout_nz=%b, expected all 0",
                     out_wr_en, outstanding, rd_req, err_unexpected, out_dout != '0);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd_data = rand_word();
            @(negedge memclk);
            n_checks++;
            if (out_wr_en !== '0 || err_unexpected !== 1'b1) begin
                n_errors++;
                $display("FAIL rmid_after[%0d]: wr_en=%b err=%b, expected 0 and 1", i, out_wr_en, err_unexpected);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int            tags[$];
        int            beat = 0;
        int            ptr = NQ - 1;
        int            exp_pick, cur_id;
        logic [NQ-1:0] exp_wr = '0;
        logic [WW-1:0] exp_dout = '0;
        logic [NQ-1:0] dec_elig = '0;
        int            dec_ptr = NQ - 1;
        int            dec_size = 0;
        bit            prev_req = 1'b0;
        logic [QW-1:0] prev_id = '0;
        cur_id = 0;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge memclk);
            n_checks++;
            if (out_wr_en !== exp_wr) begin
                n_errors++;
                $display("FAIL rnd_wr_en[%0d]: got %b expected %b", cyc, out_wr_en, exp_wr);
            end
            if (exp_wr != '0) begin
                n_checks++;
                if (out_dout !== exp_dout) begin
                    n_errors++;
                    $display("FAIL rnd_dout[%0d]: got %h expected %h", cyc, out_dout, exp_dout);
                end
            end
            n_checks++;
            if (int'(outstanding) != tags.size()) begin
                n_errors++;
                $display("FAIL rnd_outst[%0d]: got %0d expected %0d", cyc, outstanding, tags.size());
            end
            if (rd_req && !prev_req) begin
                exp_pick = rr_pick(dec_ptr, dec_elig);
                n_checks++;
                if (dec_size >= MO || exp_pick < 0 || rd_req_queue_id !== exp_pick[QW-1:0]) begin
                    n_errors++;
                    $display("FAIL rnd_req_id[%0d]: got %0d expected %0d (occupancy %0d)",
                             cyc, rd_req_queue_id, exp_pick, dec_size);
                end
                cur_id = (exp_pick < 0) ? 0 : exp_pick;
            end else if (rd_req && prev_req) begin
                n_checks++;
                if (rd_req_queue_id !== prev_id) begin
                    n_errors++;
                    $display("FAIL rnd_req_hold[%0d]: got %0d expected %0d", cyc, rd_req_queue_id, prev_id);
                end
            end
            prev_req = rd_req;
            prev_id  = rd_req_queue_id;

            mem_queue_empty = NQ'($urandom);
            out_almost_full = ($urandom_range(0, 3) == 0) ? NQ'($urandom) : '0;
            rd_req_ready    = 1'($urandom_range(0, 1));
            rd_data_valid   = (tags.size() > 0) && ($urandom_range(0, 9) < 6);
            rd_data         = rand_word();

            dec_elig = ~mem_queue_empty & ~out_almost_full;
            dec_ptr  = ptr;
            dec_size = tags.size();
            exp_wr   = '0;
            if (rd_data_valid) begin
                exp_wr   = NQ'(1) << tags[0];
                exp_dout = rd_data;
                beat++;
                if (beat == BL) begin
                    beat = 0;
                    void'(tags.pop_front());
                end
            end
            if (rd_req && rd_req_ready) begin
                tags.push_back(cur_id);
                ptr = cur_id;
            end
        end
        n_checks++;
        if (err_unexpected !== 1'b0) begin
            n_errors++;
            $display("FAIL rnd_err: got %b expected 0", err_unexpected);
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_hold();
        test_return();
        test_full();
        test_unexpected();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
